execute_mem_wbmem_engine: RTL and testbench



---
 rtl/execute_mem_wbmem_engine.sv | 123 ++++++++++++
 tb/tb_execute_mem_wbmem_engine.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_mem_wbmem_engine.sv
// Store-buffer write-back engine: one AXI4-Lite write per head entry,
// then a single-cycle pop, with a sticky error flag and perf counters.
`ifndef LSWIDTH_BYTE
`define LSWIDTH_BYTE 2'd0
`endif
`ifndef LSWIDTH_WORD
`define LSWIDTH_WORD 2'd2
`endif

module execute_mem_wbmem_engine #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wbmem_valid,
    input  logic [31:0]      wbmem_addr,
    input  logic [3:0]       wbmem_strb,
    input  logic [1:0]       wbmem_lswidth,
    input  logic [31:0]      wbmem_data,
    input  logic             wbmem_uncached,
    output logic             wbmem_en,
    output logic             m_awvalid,
    input  logic             m_awready,
    output logic [31:0]      m_awaddr,
    output logic [2:0]       m_awsize,
    output logic [3:0]       m_awcache,
    output logic             m_wvalid,
    input  logic             m_wready,
    output logic [31:0]      m_wdata,
    output logic [3:0]       m_wstrb,
    input  logic             m_bvalid,
    output logic             m_bready,
    input  logic [1:0]       m_bresp,
    output logic             o_busy,
    output logic             o_err,
    output logic [CNT_W-1:0] o_cnt_store,
    output logic [CNT_W-1:0] o_cnt_uncached,
    output logic [CNT_W-1:0] o_cnt_stall
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP, POP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  strb_q;
    logic [1:0]  lsw_q;
    logic        unc_q;
    logic        aw_done;
    logic        w_done;
    logic        aw_hs;
    logic        w_hs;
    logic        stall;

    assign m_awvalid = (state == ADDR) && !aw_done;
    assign m_wvalid  = (state == ADDR) && !w_done;
    assign m_bready  = (state == RESP);
    assign wbmem_en  = (state == POP);
    assign o_busy    = (state != IDLE);

    assign m_awaddr  = addr_q;
    assign m_awsize  = (lsw_q == `LSWIDTH_BYTE) ? 3'b000 : 3'b010;
    assign m_awcache = unc_q ? 4'b0000 : 4'b1111;
    assign m_wdata   = data_q;
    assign m_wstrb   = strb_q;

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;

    // A handshake completing this cycle is not a stall cycle.
    assign stall = ((state == ADDR) &&
                    ((m_awvalid && !m_awready) || (m_wvalid && !m_wready))) ||
                   ((state == RESP) && !m_bvalid);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (wbmem_valid) state_nxt = ADDR;
            ADDR: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = RESP;
            RESP: if (m_bvalid) state_nxt = POP;
            POP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            addr_q         <= '0;
            data_q         <= '0;
            strb_q         <= '0;
            lsw_q          <= '0;
            unc_q          <= 1'b0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            o_err          <= 1'b0;
            o_cnt_store    <= '0;
            o_cnt_uncached <= '0;
            o_cnt_stall    <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && wbmem_valid) begin
                addr_q  <= wbmem_addr;
                data_q  <= wbmem_data;
                strb_q  <= wbmem_strb;
                lsw_q   <= wbmem_lswidth;
                unc_q   <= wbmem_uncached;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if ((state == RESP) && m_bvalid && (m_bresp != 2'b00)) o_err <= 1'b1;
            if (state == POP) begin
                o_cnt_store <= o_cnt_store + CNT_W'(1);
                if (unc_q) o_cnt_uncached <= o_cnt_uncached + CNT_W'(1);
            end
            if (stall) o_cnt_stall <= o_cnt_stall + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_execute_mem_wbmem_engine.sv
// Scoreboard bench for execute_mem_wbmem_engine with a configurable
// AXI4-Lite write slave and directed store vectors.
`ifndef LSWIDTH_BYTE
`define LSWIDTH_BYTE 2'd0
`endif
`ifndef LSWIDTH_WORD
`define LSWIDTH_WORD 2'd2
`endif

module tb_execute_mem_wbmem_engine;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  cache;
        logic [31:0] data;
        logic [3:0]  strb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbmem_valid;
    logic [31:0] wbmem_addr;
    logic [3:0]  wbmem_strb;
    logic [1:0]  wbmem_lswidth;
    logic [31:0] wbmem_data;
    logic        wbmem_uncached;
    logic        wbmem_en;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awsize;
    logic [3:0]  m_awcache;
    logic        m_wvalid;
    logic        m_wready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid;
    logic        m_bready;
    logic [1:0]  m_bresp;
    logic        o_busy;
    logic        o_err;
    logic [31:0] o_cnt_store;
    logic [31:0] o_cnt_uncached;
    logic [31:0] o_cnt_stall;

    execute_mem_wbmem_engine #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .wbmem_valid(wbmem_valid), .wbmem_addr(wbmem_addr),
        .wbmem_strb(wbmem_strb), .wbmem_lswidth(wbmem_lswidth),
        .wbmem_data(wbmem_data), .wbmem_uncached(wbmem_uncached),
        .wbmem_en(wbmem_en),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_awaddr(m_awaddr), .m_awsize(m_awsize), .m_awcache(m_awcache),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .o_busy(o_busy), .o_err(o_err),
        .o_cnt_store(o_cnt_store), .o_cnt_uncached(o_cnt_uncached),
        .o_cnt_stall(o_cnt_stall)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    exp_t sb[$];

    int aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [1:0] bresp_cfg = 2'b00;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int awv_n = 0, wv_n = 0;
    int busy_cyc = 0, en_cyc = 0;
    logic prev_en = 1'b0;

    logic [31:0] cap_awaddr, cap_wdata;
    logic [2:0]  cap_awsize;
    logic [3:0]  cap_awcache, cap_wstrb;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (m_awvalid && m_awready) begin
            cap_awaddr  <= m_awaddr;
            cap_awsize  <= m_awsize;
            cap_awcache <= m_awcache;
        end
        if (m_wvalid && m_wready) begin
            cap_wdata <= m_wdata;
            cap_wstrb <= m_wstrb;
        end
    end

    // Slave: readiness decided at the falling edge from per-channel delays.
    initial begin
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (m_awvalid) begin
                m_awready = (aw_cnt >= aw_delay);
                aw_cnt++;
                awv_n++;
            end else begin
                m_awready = 1'b0;
                aw_cnt = 0;
            end
            if (m_wvalid) begin
                m_wready = (w_cnt >= w_delay);
                w_cnt++;
                wv_n++;
            end else begin
                m_wready = 1'b0;
                w_cnt = 0;
            end
            if (m_bready) begin
                m_bvalid = (b_cnt >= b_delay);
                b_cnt++;
            end else begin
                m_bvalid = 1'b0;
                b_cnt = 0;
            end
            m_bresp = bresp_cfg;
        end
    end

    // Monitor: every pop is matched against the oldest expected write.
    always @(negedge clk) begin
        if (wbmem_en && !reset) begin
            en_cyc = cyc;
            chk("no_double_en", {31'd0, prev_en}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pop", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("awaddr", cap_awaddr, e.addr);
                chk("awsize", {29'd0, cap_awsize}, {29'd0, e.size});
                chk("awcache", {28'd0, cap_awcache}, {28'd0, e.cache});
                chk("wdata", cap_wdata, e.data);
                chk("wstrb", {28'd0, cap_wstrb}, {28'd0, e.strb});
            end
        end
        prev_en = wbmem_en;
    end

    task automatic drive(input logic [31:0] a, input logic [3:0] s,
                         input logic [1:0] w, input logic [31:0] d,
                         input logic u);
        wbmem_addr     = a;
        wbmem_strb     = s;
        wbmem_lswidth  = w;
        wbmem_data     = d;
        wbmem_uncached = u;
    endtask

    task automatic wait_busy(input string name);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_busy) begin
                ok = 1;
                break;
            end
        end
        busy_cyc = cyc;
        if (!ok) chk({name, "_busy_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_en(input string name);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wbmem_en) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({name, "_pop_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic issue(input string name, input logic [31:0] a,
                         input logic [3:0] s, input logic [1:0] w,
                         input logic [31:0] d, input logic u,
                         input exp_t e);
        sb.push_back(e);
        drive(a, s, w, d, u);
        wbmem_valid = 1'b1;
        wait_busy(name);
        wbmem_valid = 1'b0;
        wait_en(name);
        @(negedge clk);
    endtask

    logic [31:0] st0, unc0, stl0;
    int cap_t[3];

    initial begin
        reset = 1'b1;
        wbmem_valid = 1'b0;
        drive(32'd0, 4'd0, `LSWIDTH_WORD, 32'd0, 1'b0);
        #13;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_awvalid", {31'd0, m_awvalid}, 32'd0);
        chk("rst_wvalid", {31'd0, m_wvalid}, 32'd0);
        chk("rst_bready", {31'd0, m_bready}, 32'd0);
        chk("rst_en", {31'd0, wbmem_en}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        chk("rst_awaddr", m_awaddr, 32'd0);
        chk("rst_cnt_store", o_cnt_store, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue("zero_wait", 32'h8000_0010, 4'hF, `LSWIDTH_WORD,
              32'hDEAD_BEEF, 1'b0,
              '{32'h8000_0010, 3'd2, 4'hF, 32'hDEAD_BEEF, 4'hF});
        chk("zw_pop_latency", en_cyc - busy_cyc, 32'd2);
        chk("zw_cnt_store", o_cnt_store, 32'd1);
        chk("zw_cnt_stall", o_cnt_stall, 32'd0);
        chk("zw_cnt_unc", o_cnt_uncached, 32'd0);

        unc0 = o_cnt_uncached;
        issue("uncached_byte", 32'hBFD0_0003, 4'h8, `LSWIDTH_BYTE,
              32'h5A5A_5A5A, 1'b1,
              '{32'hBFD0_0003, 3'd0, 4'h0, 32'h5A5A_5A5A, 4'h8});
        chk("unc_cnt", o_cnt_uncached - unc0, 32'd1);
        chk("unc_cnt_store", o_cnt_store, 32'd2);

        aw_delay = 3;
        b_delay = 2;
        awv_n = 0;
        wv_n = 0;
        stl0 = o_cnt_stall;
        st0 = o_cnt_store;
        issue("skewed", 32'h0000_1234, 4'h3, `LSWIDTH_WORD,
              32'h1122_3344, 1'b0,
              '{32'h0000_1234, 3'd2, 4'hF, 32'h1122_3344, 4'h3});
        chk("skew_awvalid_cycles", awv_n, 32'd4);
        chk("skew_wvalid_cycles", wv_n, 32'd1);
        chk("skew_stall", o_cnt_stall - stl0, 32'd5);
        chk("skew_one_pop", o_cnt_store - st0, 32'd1);
        aw_delay = 0;
        b_delay = 0;

        bresp_cfg = 2'b10;
        issue("err_resp", 32'h0000_2000, 4'hF, `LSWIDTH_WORD,
              32'hCAFE_F00D, 1'b0,
              '{32'h0000_2000, 3'd2, 4'hF, 32'hCAFE_F00D, 4'hF});
        chk("err_set", {31'd0, o_err}, 32'd1);
        bresp_cfg = 2'b00;
        issue("err_then_ok", 32'h0000_2004, 4'hF, `LSWIDTH_WORD,
              32'h0BAD_F00D, 1'b0,
              '{32'h0000_2004, 3'd2, 4'hF, 32'h0BAD_F00D, 4'hF});
        chk("err_sticky", {31'd0, o_err}, 32'd1);

        st0 = o_cnt_store;
        sb.push_back('{32'h0000_3000, 3'd2, 4'hF, 32'hA000_0000, 4'hF});
        sb.push_back('{32'h0000_3004, 3'd2, 4'hF, 32'hA000_0001, 4'hF});
        sb.push_back('{32'h0000_3008, 3'd2, 4'hF, 32'hA000_0002, 4'hF});
        drive(32'h0000_3000, 4'hF, `LSWIDTH_WORD, 32'hA000_0000, 1'b0);
        wbmem_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_busy("b2b");
            cap_t[k] = busy_cyc;
            wait_en("b2b");
            if (k < 2)
                drive(32'h0000_3004 + 32'(k * 4), 4'hF, `LSWIDTH_WORD,
                      32'hA000_0001 + 32'(k), 1'b0);
            else
                wbmem_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_gap0", cap_t[1] - cap_t[0], 32'd4);
        chk("b2b_gap1", cap_t[2] - cap_t[1], 32'd4);
        chk("b2b_pops", o_cnt_store - st0, 32'd3);
        chk("b2b_sb_empty", sb.size(), 32'd0);

        b_delay = 50;
        drive(32'h0000_4000, 4'hF, `LSWIDTH_WORD, 32'h7777_7777, 1'b0);
        wbmem_valid = 1'b1;
        wait_busy("rst_mid");
        wbmem_valid = 1'b0;
        for (int i = 0; i < 20 && !m_bready; i++) @(negedge clk);
        chk("rst_mid_in_resp", {31'd0, m_bready}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_mid_bready", {31'd0, m_bready}, 32'd0);
        chk("rst_mid_en", {31'd0, wbmem_en}, 32'd0);
        chk("rst_mid_store", o_cnt_store, 32'd0);
        chk("rst_mid_unc", o_cnt_uncached, 32'd0);
        chk("rst_mid_stall", o_cnt_stall, 32'd0);
        chk("rst_mid_err", {31'd0, o_err}, 32'd0);
        sb.delete();
        b_delay = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
